// File: rtl/segment_display_arbiter.sv
// Grants the shared seven-segment display to one of two frame requesters, round-robin, with a minimum hold.
// Accepted frame appears on o_digits_out one cycle after accept; the non-owner is held off (ready low) until the hold expires.
module segment_display_arbiter #(
  parameter int TICK_DIVIDER   = 60000,
  parameter int MIN_HOLD_TICKS = 100,
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_BITS     = 5
) (
  input  logic                             i_clock,
  input  logic                             i_reset_n,
  input  logic                             i_req0_valid,
  output logic                             o_req0_ready,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] i_req0_digits,
  input  logic                             i_req1_valid,
  output logic                             o_req1_ready,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] i_req1_digits,
  output logic [NUM_DIGITS*DIGIT_BITS-1:0] o_digits_out,
  output logic                             o_owner,
  output logic                             o_frame_update
);

  localparam int FW = NUM_DIGITS * DIGIT_BITS;
  localparam int TW = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam int HW = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIVIDER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD_TICKS);

  typedef enum logic [1:0] {IDLE, HOLD, EXPIRED} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic          r_ptr;
  logic          w_ptr_nxt;
  logic          w_rdy0;
  logic          w_rdy1;
  logic [FW-1:0] r_digits;
  logic          r_owner;
  logic          r_frame_update;

  // Async assert, synchronous release; ready is gated until release completes.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_ptr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_ptr_nxt   = r_ptr;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      HOLD: begin
        w_rdy0 = i_req0_valid & ~r_owner;
        w_rdy1 = i_req1_valid & r_owner;
        if (w_tick && (r_hold_cnt != HOLD_LAST)) w_hold_nxt = r_hold_cnt + 1'b1;
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = EXPIRED;
      end
      default: begin
        if (i_req0_valid && i_req1_valid) begin
          w_rdy0    = ~r_ptr;
          w_rdy1    = r_ptr;
          w_ptr_nxt = ~r_ptr;
        end else begin
          w_rdy0 = i_req0_valid;
          w_rdy1 = i_req1_valid;
        end
        if (i_req0_valid || i_req1_valid) begin
          w_state_nxt = HOLD;
          w_hold_nxt  = '0;
        end
      end
    endcase
    if (!w_rst_n) begin
      w_rdy0 = 1'b0;
      w_rdy1 = 1'b0;
    end
  end

  // Display register only moves on accept; never blanked outside reset.
  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_digits       <= '0;
      r_owner        <= 1'b0;
      r_frame_update <= 1'b0;
    end else begin
      r_frame_update <= w_rdy0 | w_rdy1;
      if (w_rdy1) begin
        r_digits <= i_req1_digits;
        r_owner  <= 1'b1;
      end else if (w_rdy0) begin
        r_digits <= i_req0_digits;
        r_owner  <= 1'b0;
      end
    end
  end

  assign o_req0_ready   = w_rdy0;
  assign o_req1_ready   = w_rdy1;
  assign o_digits_out   = r_digits;
  assign o_owner        = r_owner;
  assign o_frame_update = r_frame_update;

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Directed bench for segment_display_arbiter: one instance with a 2-tick hold, one with zero hold.
// Accepts predicted by the bench are queued and compared when the display register updates.
module tb_segment_display_arbiter;

  localparam int TD    = 4;
  localparam int NB    = 20;
  localparam int MIN_A = 2;
  localparam int MIN_B = 0;

  typedef struct packed {
    logic [NB-1:0] frame;
    logic          owner;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          v0   [2];
  logic          v1   [2];
  logic [NB-1:0] d0   [2];
  logic [NB-1:0] d1   [2];
  logic          r0   [2];
  logic          r1   [2];
  logic [NB-1:0] dout [2];
  logic          own  [2];
  logic          fu   [2];

  exp_t          sb [$];
  logic [NB-1:0] exp_dout [2];
  logic          exp_own  [2];
  bit            m_ptr    [2];
  bit            m_owner  [2];
  int            m_free   [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  segment_display_arbiter #(
    .TICK_DIVIDER(TD), .MIN_HOLD_TICKS(MIN_A), .NUM_DIGITS(4), .DIGIT_BITS(5)
  ) u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_valid(v0[0]), .o_req0_ready(r0[0]), .i_req0_digits(d0[0]),
    .i_req1_valid(v1[0]), .o_req1_ready(r1[0]), .i_req1_digits(d1[0]),
    .o_digits_out(dout[0]), .o_owner(own[0]), .o_frame_update(fu[0])
  );

  segment_display_arbiter #(
    .TICK_DIVIDER(TD), .MIN_HOLD_TICKS(MIN_B), .NUM_DIGITS(4), .DIGIT_BITS(5)
  ) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req0_valid(v0[1]), .o_req0_ready(r0[1]), .i_req0_digits(d0[1]),
    .i_req1_valid(v1[1]), .o_req1_ready(r1[1]), .i_req1_digits(d1[1]),
    .o_digits_out(dout[1]), .o_owner(own[1]), .o_frame_update(fu[1])
  );

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [NB-1:0] rnd();
    return NB'($urandom);
  endfunction

  // Cycle 0 after release is still inside the reset synchroniser; the tick counter starts at cycle 1.
  function automatic bit is_tick(input int c);
    return (c >= 1) && (((c - 1) % TD) == TD - 1);
  endfunction

  // First cycle in which arbitration is open again after an accept from IDLE/EXPIRED in cycle a.
  function automatic int free_at(input int a, input int min_ticks);
    int r;
    int n;
    r = a + 2;
    n = 0;
    if (min_ticks > 0) begin
      for (int c = a + 1; n < min_ticks; c++) begin
        if (is_tick(c)) begin
          n++;
          r = c + 2;
        end
      end
    end
    return r;
  endfunction

  task automatic next();
    @(negedge clk);
    cyc++;
  endtask

  task automatic sample_outputs(input int k);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_dout[k] = e.frame;
      exp_own[k]  = e.owner;
      check("frame_update_pulse", NB'(fu[k]), NB'(1));
    end else begin
      check("frame_update_idle", NB'(fu[k]), NB'(0));
    end
    check("digits_out", dout[k], exp_dout[k]);
    check("owner", NB'(own[k]), NB'(exp_own[k]));
  endtask

  task automatic drive_check(input int k, input bit a0, input bit a1, input bit e0, input bit e1,
                             input logic [NB-1:0] f0, input logic [NB-1:0] f1, input string tag);
    v0[k] = a0;
    v1[k] = a1;
    d0[k] = f0;
    d1[k] = f1;
    #1;
    sample_outputs(k);
    check({tag, "_ready0"}, NB'(r0[k]), NB'(e0));
    check({tag, "_ready1"}, NB'(r1[k]), NB'(e1));
    if (a0 && e0) sb.push_back('{frame: f0, owner: 1'b0});
    if (a1 && e1) sb.push_back('{frame: f1, owner: 1'b1});
  endtask

  // Behavioural arbitration model; handoff=1 offers one requester at a time until it is served.
  task automatic run_model(input int k, input int min_ticks, input int n, input bit handoff);
    bit a0, a1, e0, e1, cur;
    int waited;
    cur    = 1'b0;
    waited = 0;
    repeat (n) begin
      next();
      a0 = handoff ? !cur : 1'b1;
      a1 = handoff ? cur : 1'b1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (cyc >= m_free[k]) begin
        if (a0 && a1) begin
          e0 = !m_ptr[k];
          e1 = m_ptr[k];
          m_ptr[k] = !m_ptr[k];
        end else begin
          e0 = a0;
          e1 = a1;
        end
        if (e0 || e1) begin
          m_owner[k] = e1;
          m_free[k]  = free_at(cyc, min_ticks);
        end
      end else begin
        e0 = a0 && !m_owner[k];
        e1 = a1 && m_owner[k];
      end
      drive_check(k, a0, a1, e0, e1, rnd(), rnd(), handoff ? "handoff" : "tie");
      if (handoff) begin
        waited++;
        if (cur ? e1 : e0) begin
          check("handoff_within_2", NB'(waited <= 2), NB'(1));
          cur    = !cur;
          waited = 0;
        end
      end
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      exp_dout[k] = '0;
      exp_own[k]  = 1'b0;
      m_ptr[k]    = 1'b0;
      m_owner[k]  = 1'b0;
      m_free[k]   = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int s;
    for (int k = 0; k < 2; k++) begin
      v0[k] = 1'b0;
      v1[k] = 1'b0;
      d0[k] = '0;
      d1[k] = '0;
    end
    clear_model();

    #2;
    for (int k = 0; k < 2; k++) begin
      check("reset_digits", dout[k], '0);
      check("reset_owner", NB'(own[k]), NB'(0));
      check("reset_update", NB'(fu[k]), NB'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;

    next();
    drive_check(0, 0, 0, 0, 0, '0, '0, "sync");
    next();
    drive_check(0, 1, 0, 1, 0, {5'h0A, 5'h1B, 5'h00, 5'h19}, rnd(), "t1_accept");
    acc = cyc;

    s = free_at(acc, MIN_A);
    while (cyc < s) begin
      next();
      drive_check(0, 0, 1, 0, 1'(cyc == s), rnd(), rnd(), "t3_wait");
    end
    acc = cyc;
    next();
    drive_check(0, 0, 0, 0, 0, rnd(), rnd(), "t3_after");

    // Owner refresh lands on a tick cycle: frame must latch and the tick still counts.
    next();
    drive_check(0, 0, 1, 0, 1, rnd(), 20'hFFFFF, "t4_owner_update");
    s = free_at(acc, MIN_A);
    while (cyc < s) begin
      next();
      drive_check(0, 1, 0, 1'(cyc == s), 0, rnd(), rnd(), "t4_expiry");
    end

    next();
    drive_check(0, 1, 1, 1, 0, rnd(), rnd(), "t6_pre");
    next();
    #1;
    sample_outputs(0);
    check("t6_hold_ready0", NB'(r0[0]), NB'(1));
    check("t6_hold_ready1", NB'(r1[0]), NB'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_digits", dout[0], '0);
    check("t6_async_owner", NB'(own[0]), NB'(0));
    check("t6_async_update", NB'(fu[0]), NB'(0));
    check("t6_async_ready0", NB'(r0[0]), NB'(0));
    check("t6_async_ready1", NB'(r1[0]), NB'(0));
    clear_model();
    @(negedge clk);
    check("t6_held_digits", dout[0], '0);
    check("t6_held_ready0", NB'(r0[0]), NB'(0));
    rst_n = 1'b1;
    cyc   = -1;
    next();
    drive_check(0, 1, 1, 0, 0, rnd(), rnd(), "t6_sync");

    run_model(0, MIN_A, 30, 1'b0);
    next();
    drive_check(0, 0, 0, 0, 0, rnd(), rnd(), "a_drain");

    run_model(1, MIN_B, 12, 1'b1);
    run_model(1, MIN_B, 10, 1'b0);
    next();
    drive_check(1, 0, 0, 0, 0, rnd(), rnd(), "b_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
